uart_rx_capture: RTL
====================

// Module: uart_rx_capture
// PURPOSE
//  8N1 UART receiver that consumes the serial uart_tx line driven by the SoC top.
//  Recovers bytes by mid-bit sampling against CLK100MHZ and queues them in a FWFT FIFO.
//  Drains through a valid/ready port to a bench checker or console logger.
//  Flags framing errors and FIFO overflow.
// PARAMETERS
//  CLK_HZ      100000000  input clock frequency in Hz
//  BAUD        115200     line rate; DIV = CLK_HZ/BAUD (integer, >= 4), 868 at defaults
//  FIFO_DEPTH  16         byte FIFO entries, power of 2, >= 2
// PORTS
//  CLK100MHZ   in   1                      system clock
//  fpga_rst    in   1                      synchronous reset, active-low
//  rxd         in   1                      async serial input, idle high (SoC uart_tx)
//  out_data    out  8                      FIFO head byte, valid when out_valid=1
//  out_valid   out  1                      FIFO not empty
//  out_ready   in   1                      consumer pop; pop occurs when out_valid & out_ready
//  frame_err   out  1                      1-cycle pulse on bad stop bit
//  overflow    out  1                      sticky; set when a byte is dropped on full FIFO
//  fifo_count  out  $clog2(FIFO_DEPTH)+1   bytes currently held
// BEHAVIOUR
//  Reset (fpga_rst=0 at a clock edge): FSM=IDLE; all counters cleared; FIFO emptied.
//   Synchroniser flops load 1. out_valid=0, out_data=0, frame_err=0, overflow=0, fifo_count=0.
//  Reset mid-frame aborts the frame; the partial byte is never pushed.
//  rxd passes through a 2-flop synchroniser (rxs); the FSM sees rxs only.
//  FSM states and baud counter bcnt:
//   IDLE  : rxs 1->0 edge -> START, bcnt=DIV/2-1.
//   START : at bcnt==0, sample rxs. If 0 -> DATA, bcnt=DIV-1, bit index=0.
//           If 1 (glitch) -> IDLE; no flag raised.
//   DATA  : at each bcnt==0, shift in rxs (LSB first) and reload bcnt=DIV-1.
//           After bit 7 -> STOP.
//   STOP  : at bcnt==0, sample rxs.
//           1 -> push byte, -> IDLE.
//           0 -> frame_err=1 for one cycle, byte discarded, -> BREAK.
//   BREAK : wait until rxs==1, then -> IDLE (a held-low line produces exactly one frame_err).
//  All bits are sampled at mid-bit; the falling-edge detect uses the rxs delayed by one cycle.
//  Push: the byte appears on out_data/out_valid on the cycle after the stop-bit sample edge.
//  FIFO is first-word-fall-through: out_data = head entry whenever out_valid=1.
//   out_data holds its last value when the FIFO is empty.
//  Push is accepted if fifo_count<FIFO_DEPTH, or if a pop occurs in the same cycle.
//   Otherwise the byte is dropped and overflow is set; overflow clears only on reset.
//  Simultaneous push and pop: fifo_count is unchanged; pointers wrap modulo FIFO_DEPTH.
//  A pop with out_valid=0 is ignored; fifo_count never underflows.
//  A new frame can start in IDLE on the cycle after STOP; back-to-back frames are supported.
// TESTING (CLK_HZ=800, BAUD=100 -> DIV=8)
//  Byte 0x55 sent with out_ready=1: out_data=0x55, out_valid high for 1 cycle,
//   first valid cycle 3 cycles after the stop-bit midpoint; frame_err=0.
//  Bytes 0xA5, 0x3C, 0xFF back-to-back with out_ready=0:
//   fifo_count=3; pops return A5, 3C, FF in order, then out_valid=0.
//  0x12 sent with stop bit=0, line then held low for 40 cycles:
//   exactly one frame_err pulse; fifo_count stays 0; next good 0x34 is received.
//  3-cycle low glitch on idle line: FSM returns to IDLE, no push, no frame_err.
//  FIFO_DEPTH=4, 5 bytes sent with out_ready=0:
//   fifo_count=4, overflow=1, 5th byte absent from the FIFO.
//   A push coinciding with a pop on full is accepted.
//  fpga_rst=0 during bit 4 of a frame, then released:
//   all outputs at reset values; next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_capture_if.sv
// Byte drain port of the UART receiver: FWFT head plus valid/ready pop handshake.
interface uart_rx_capture_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: mid-bit sampling of a synchronised rxd, bytes queued in a
// first-word-fall-through FIFO drained over a valid/ready interface.
module uart_rx_capture #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK100MHZ,
    input  logic                          fpga_rst,
    input  logic                          rxd,
    uart_rx_capture_if.master             out_if,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int BCW = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [BCW-1:0] HALF = BCW'(DIV / 2 - 1);
    localparam logic [BCW-1:0] FULL = BCW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t         state, state_n;
    logic [BCW-1:0] bcnt, bcnt_n;
    logic [2:0]     bidx, bidx_n;
    logic [7:0]     shreg, shreg_n;
    logic           push, ferr_n;

    logic [1:0]     sync_q;
    logic           rxs, rxs_d;

    // Idle-high reset value keeps reset release from looking like a start edge.
    always_ff @(posedge CLK100MHZ) begin
        if (!fpga_rst) begin
            sync_q <= 2'b11;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd};
            rxs_d  <= rxs;
        end
    end
    assign rxs = sync_q[1];

    always_ff @(posedge CLK100MHZ) begin
        if (!fpga_rst) begin
            state     <= IDLE;
            bcnt      <= '0;
            bidx      <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bcnt      <= bcnt_n;
            bidx      <= bidx_n;
            shreg     <= shreg_n;
            frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        bcnt_n  = bcnt;
        bidx_n  = bidx;
        shreg_n = shreg;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs && rxs_d) begin
                    state_n = START;
                    bcnt_n  = HALF;
                end
            end
            START: begin
                if (bcnt == '0) begin
                    if (!rxs) begin
                        state_n = DATA;
                        bcnt_n  = FULL;
                        bidx_n  = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    bcnt_n = bcnt - 1'b1;
                end
            end
            DATA: begin
                if (bcnt == '0) begin
                    shreg_n = {rxs, shreg[7:1]};
                    bcnt_n  = FULL;
                    bidx_n  = bidx + 3'd1;
                    if (bidx == 3'd7) state_n = STOP;
                end else begin
                    bcnt_n = bcnt - 1'b1;
                end
            end
            STOP: begin
                if (bcnt == '0) begin
                    if (rxs) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BRK;
                    end
                end else begin
                    bcnt_n = bcnt - 1'b1;
                end
            end
            BRK: begin
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [7:0]    last_q;
    logic          pop, push_ok;

    assign pop     = out_if.out_valid & out_if.out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push & ((fifo_count < CW'(FIFO_DEPTH)) | pop);

    always_ff @(posedge CLK100MHZ) begin
        if (push_ok) mem[wptr] <= shreg;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!fpga_rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            last_q     <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
            last_q <= out_if.out_data;
        end
    end

    // Empty FIFO keeps presenting whatever byte was last on the port.
    assign out_if.out_valid = (fifo_count != '0);
    assign out_if.out_data  = out_if.out_valid ? mem[rptr] : last_q;
endmodule
